sd_cmd_ctrl: RTL and testbench

SD_CMD_CTRL -- requirements
Module: sd_cmd_ctrl

---
 rtl/sd_cmd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// SD CMD line controller: sends a 48-bit command frame and optionally receives a 48-bit response.
// States: IDLE accept | SEND drive frame | WAIT hunt start bit | RECV shift response | GAP idle line, then done

module crc7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);
    logic [6:0] crc_q;
    logic       fb;

    assign fb    = din_i ^ crc_q[6];
    assign crc_o = crc_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) crc_q <= '0;
        else if (en_i)      crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
endmodule

module sd_cmd_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_in,
    output logic        done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        crc_err,
    output logic        timeout_err,
    output logic        end_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;

    state_t        state_q;
    logic [5:0]    idx_q;
    logic [31:0]   arg_q;
    logic [1:0]    rtype_q;
    logic [5:0]    n_q;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic [37:0]   sr_q;
    logic          out_q, oe_q, done_q;
    logic          crc_err_q, tmo_err_q, end_err_q;
    logic [5:0]    resp_idx_q;
    logic [31:0]   resp_arg_q;

    logic [39:0]   head;
    logic [5:0]    hidx;
    logic [2:0]    csel;
    logic [6:0]    crc;
    logic          fbit, crc_clr, crc_en, crc_din;

    assign head = {2'b01, idx_q, arg_q};
    assign hidx = 6'd39 - n_q;
    // CRC bits occupy n = 40..46 and 40 is a multiple of 8, so the low bits pick crc[46-n]
    assign csel = 3'd6 - n_q[2:0];

    always_comb begin
        fbit = 1'b1;
        if (n_q < 6'd40)      fbit = head[hidx];
        else if (n_q < 6'd47) fbit = crc[csel];
    end

    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = sd_cmd_in;
        case (state_q)
            S_IDLE: crc_clr = cmd_valid;
            S_SEND: begin
                crc_clr = clk_en && (n_q == 6'd48);
                crc_en  = clk_en && (n_q < 6'd40);
                crc_din = fbit;
            end
            S_WAIT:  crc_en = clk_en && !sd_cmd_in;
            S_RECV:  crc_en = clk_en && (n_q <= 6'd39);
            default: ;
        endcase
    end

    crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (crc_din),
        .crc_o (crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            arg_q      <= '0;
            rtype_q    <= '0;
            n_q        <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            sr_q       <= '0;
            out_q      <= 1'b1;
            oe_q       <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            resp_idx_q <= '0;
            resp_arg_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    idx_q     <= cmd_index;
                    arg_q     <= cmd_arg;
                    rtype_q   <= resp_type;
                    n_q       <= '0;
                    crc_err_q <= 1'b0;
                    tmo_err_q <= 1'b0;
                    end_err_q <= 1'b0;
                    state_q   <= S_SEND;
                end
                S_SEND: if (clk_en) begin
                    if (n_q == 6'd48) begin
                        oe_q    <= 1'b0;
                        out_q   <= 1'b1;
                        tmo_q   <= '0;
                        gap_q   <= '0;
                        state_q <= (rtype_q != 2'd0) ? S_WAIT : S_GAP;
                    end else begin
                        out_q <= fbit;
                        oe_q  <= 1'b1;
                        n_q   <= n_q + 6'd1;
                    end
                end
                S_WAIT: if (clk_en) begin
                    if (!sd_cmd_in) begin
                        n_q     <= 6'd1;
                        state_q <= S_RECV;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            tmo_err_q <= 1'b1;
                            gap_q     <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_RECV: if (clk_en) begin
                    // only payload bits are kept; CRC and end bit are checked as they arrive
                    if (n_q >= 6'd2 && n_q <= 6'd39) sr_q <= {sr_q[36:0], sd_cmd_in};
                    if (n_q >= 6'd40 && n_q <= 6'd46 && sd_cmd_in != crc[csel] && rtype_q != 2'd2)
                        crc_err_q <= 1'b1;
                    if (n_q == 6'd47) begin
                        if (!sd_cmd_in) end_err_q <= 1'b1;
                        resp_idx_q <= sr_q[37:32];
                        resp_arg_q <= sr_q[31:0];
                        gap_q      <= '0;
                        state_q    <= S_GAP;
                    end else begin
                        n_q <= n_q + 6'd1;
                    end
                end
                S_GAP: if (clk_en) begin
                    oe_q <= 1'b0;
                    if (gap_q == GW'(GAP - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign sd_cmd_out  = out_q;
    assign sd_cmd_oe   = oe_q;
    assign done        = done_q;
    assign resp_index  = resp_idx_q;
    assign resp_arg    = resp_arg_q;
    assign crc_err     = crc_err_q;
    assign timeout_err = tmo_err_q;
    assign end_err     = end_err_q;
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Self-checking bench for sd_cmd_ctrl: directed vector table, reset corner sequences,
// and randomized transactions checked against a polynomial-division CRC reference.

module tb_sd_cmd_ctrl;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 8;

    logic        clk = 1'b0;
    logic        reset, clk_en, cmd_valid, cmd_ready;
    logic [5:0]  cmd_index, resp_index;
    logic [31:0] cmd_arg, resp_arg;
    logic [1:0]  resp_type;
    logic        sd_cmd_out, sd_cmd_oe, sd_cmd_in, done;
    logic        crc_err, timeout_err, end_err;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .sd_cmd_out  (sd_cmd_out),
        .sd_cmd_oe   (sd_cmd_oe),
        .sd_cmd_in   (sd_cmd_in),
        .done        (done),
        .resp_index  (resp_index),
        .resp_arg    (resp_arg),
        .crc_err     (crc_err),
        .timeout_err (timeout_err),
        .end_err     (end_err)
    );

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  rt;
        bit          respond;
        logic [47:0] resp;
        int          idle;
        logic [47:0] frame;
        bit          crc_e;
        bit          end_e;
        bit          tmo_e;
        logic [5:0]  ridx;
        logic [31:0] rarg;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic s_out, s_oe, s_done;
    bit   freeze_bad, early_done;
    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // remainder of data(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [39:0] data);
        logic [46:0] v;
        v = {data, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    task automatic strobe(input logic din, input bit noise);
        int n_idle;
        sd_cmd_in = din;
        clk_en    = 1'b1;
        if (noise) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_index = 6'($urandom);
            cmd_arg   = $urandom;
            resp_type = 2'($urandom);
        end
        @(posedge clk); #1;
        clk_en    = 1'b0;
        cmd_valid = 1'b0;
        s_out  = sd_cmd_out;
        s_oe   = sd_cmd_oe;
        s_done = done;
        n_idle = $urandom_range(0, 2);
        repeat (n_idle) begin
            sd_cmd_in = 1'($urandom);
            @(posedge clk); #1;
            if (sd_cmd_out !== s_out || sd_cmd_oe !== s_oe || done !== 1'b0) freeze_bad = 1'b1;
        end
    endtask

    task automatic do_accept(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        int cnt = 0;
        while (cmd_ready !== 1'b1 && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        cmd_valid = 1'b1;
        clk_en    = 1'($urandom_range(0, 1));
        sd_cmd_in = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        clk_en    = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [47:0] got_frame = '0;
        bit oe_bad = 1'b0;
        bit seen   = 1'b0;
        int cnt    = 0;
        int exp_cnt;
        freeze_bad = 1'b0;
        early_done = 1'b0;
        do_accept(v.idx, v.arg, v.rt);
        check("accept_ready_low", 64'(cmd_ready), 64'd0);
        check("accept_flags_clear", 64'({crc_err, timeout_err, end_err}), 64'd0);
        for (int i = 0; i < 48; i++) begin
            strobe(1'b1, 1'b1);
            got_frame = {got_frame[46:0], s_out};
            if (s_oe !== 1'b1) oe_bad = 1'b1;
            if (s_done) early_done = 1'b1;
        end
        check("tx_frame", 64'(got_frame), 64'(v.frame));
        check("tx_oe_high", 64'(oe_bad), 64'd0);
        strobe(1'b1, 1'b1);
        check("exit_line_released", 64'({s_oe, s_out}), 64'b01);
        if (v.rt != 2'd0 && v.respond) begin
            for (int i = 0; i < v.idle; i++) begin
                strobe(1'b1, 1'b1);
                if (s_done) early_done = 1'b1;
            end
            for (int i = 0; i < 48; i++) begin
                strobe(v.resp[47-i], 1'b1);
                if (s_done) early_done = 1'b1;
            end
        end
        while (!seen && cnt < 400) begin
            strobe(1'b1, 1'b1);
            cnt++;
            seen = s_done;
        end
        exp_cnt = (v.rt != 2'd0 && !v.respond) ? TIMEOUT + GAP : GAP;
        check("strobes_to_done", 64'(cnt), 64'(exp_cnt));
        check("no_early_done", 64'(early_done), 64'd0);
        check("crc_err", 64'(crc_err), 64'(v.crc_e));
        check("end_err", 64'(end_err), 64'(v.end_e));
        check("timeout_err", 64'(timeout_err), 64'(v.tmo_e));
        check("resp_index", 64'(resp_index), 64'(v.ridx));
        check("resp_arg", 64'(resp_arg), 64'(v.rarg));
        check("ready_after_done", 64'(cmd_ready), 64'd1);
        check("clk_en_freeze", 64'(freeze_bad), 64'd0);
    endtask

    task automatic reset_pulse();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_index = 6'd5;
        @(posedge clk); #1;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        last_idx  = '0;
        last_arg  = '0;
    endtask

    task automatic check_no_done(input string name);
        bit any = 1'b0;
        clk_en    = 1'b1;
        sd_cmd_in = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) any = 1'b1;
        end
        clk_en = 1'b0;
        check(name, 64'(any), 64'd0);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        logic [39:0] rd;
        logic [6:0]  c;
        logic        eb;
        bit          has;

        tbl[0] = '{6'd0,  32'h0, 2'd0, 1'b0, 48'h0,            0, 48'h400000000095, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0};
        tbl[1] = '{6'd17, 32'h0, 2'd1, 1'b1, 48'h110000090067, 5, 48'h510000000055, 1'b0, 1'b0, 1'b0, 6'd17, 32'h900};
        tbl[2] = '{6'd17, 32'h0, 2'd1, 1'b1, 48'h110000090065, 5, 48'h510000000055, 1'b1, 1'b0, 1'b0, 6'd17, 32'h900};
        tbl[3] = '{6'd17, 32'h0, 2'd2, 1'b1, 48'h110000090065, 5, 48'h510000000055, 1'b0, 1'b0, 1'b0, 6'd17, 32'h900};
        tbl[4] = '{6'd17, 32'h0, 2'd1, 1'b1, 48'h110000090066, 5, 48'h510000000055, 1'b0, 1'b1, 1'b0, 6'd17, 32'h900};
        tbl[5] = '{6'd17, 32'h0, 2'd1, 1'b0, 48'h0,            0, 48'h510000000055, 1'b0, 1'b0, 1'b1, 6'd17, 32'h900};
        tbl[6] = '{6'd17, 32'h0, 2'd3, 1'b1, 48'h110000090065, 2, 48'h510000000055, 1'b1, 1'b0, 1'b0, 6'd17, 32'h900};

        clk_en    = 1'b0;
        cmd_valid = 1'b1;
        cmd_index = 6'd1;
        cmd_arg   = 32'h0;
        resp_type = 2'd0;
        sd_cmd_in = 1'b1;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(cmd_ready), 64'd1);
        check("reset_line", 64'({sd_cmd_oe, sd_cmd_out, done}), 64'b010);
        check("reset_flags", 64'({crc_err, timeout_err, end_err}), 64'd0);
        check("reset_resp", 64'({resp_index, resp_arg}), 64'd0);
        reset     = 1'b0;
        cmd_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // reset in the middle of a response
        do_accept(6'd17, 32'h0, 2'd1);
        repeat (49) strobe(1'b1, 1'b0);
        repeat (3) strobe(1'b1, 1'b0);
        for (int i = 0; i < 21; i++) strobe(tbl[1].resp[47-i], 1'b0);
        reset_pulse();
        check("recv_reset_line", 64'({sd_cmd_oe, sd_cmd_out, cmd_ready, done}), 64'b0110);
        check("recv_reset_resp", 64'({resp_index, resp_arg}), 64'd0);
        check("recv_reset_flags", 64'({crc_err, timeout_err, end_err}), 64'd0);
        check_no_done("recv_reset_no_done");

        // reset at bit 20 of a command, with cmd_valid held during reset
        do_accept(6'd17, 32'h0, 2'd1);
        repeat (21) strobe(1'b1, 1'b0);
        reset_pulse();
        check("send_reset_line", 64'({sd_cmd_oe, sd_cmd_out, cmd_ready, done}), 64'b0110);
        check_no_done("send_reset_no_done");
        run_txn(tbl[0]);

        for (int t = 0; t < 30; t++) begin
            rv.idx     = 6'($urandom);
            rv.arg     = $urandom;
            rv.rt      = 2'($urandom_range(0, 3));
            rv.respond = ($urandom_range(0, 4) != 0);
            rv.idle    = $urandom_range(0, 12);
            rd[39:32]  = 8'($urandom);
            rd[31:0]   = $urandom;
            rd[39]     = 1'b0;
            c = crc7_ref(rd);
            if ($urandom_range(0, 1) == 1) c = c ^ 7'(1 << $urandom_range(0, 6));
            eb = ($urandom_range(0, 3) != 0);
            rv.resp  = {rd, c, eb};
            rv.frame = {2'b01, rv.idx, rv.arg, crc7_ref({2'b01, rv.idx, rv.arg}), 1'b1};
            has      = (rv.rt != 2'd0) && rv.respond;
            rv.crc_e = has && (rv.rt != 2'd2) && (c != crc7_ref(rd));
            rv.end_e = has && !eb;
            rv.tmo_e = (rv.rt != 2'd0) && !rv.respond;
            if (has) begin
                last_idx = rd[37:32];
                last_arg = rd[31:0];
            end
            rv.ridx = last_idx;
            rv.rarg = last_arg;
            run_txn(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
